// File: rtl/cordic_iter_if.sv
// cordic_iter_if: operand/result handshake bundle for cordic_iter.
//   in_valid/in_ready/in_mode/in_x/in_y/in_z : operand channel.
//   out_valid/out_ready/out_x/out_y/out_z     : result channel.
//   busy                                      : core is in RUN or DONE.
// Modport slave is the core side; master is the producer/consumer side.
interface cordic_iter_if #(
  parameter int DATA_W  = 17,
  parameter int ANGLE_W = 32
);
  logic               in_valid;
  logic               in_ready;
  logic               in_mode;
  logic [DATA_W-1:0]  in_x;
  logic [DATA_W-1:0]  in_y;
  logic [ANGLE_W-1:0] in_z;
  logic               out_valid;
  logic               out_ready;
  logic [DATA_W-1:0]  out_x;
  logic [DATA_W-1:0]  out_y;
  logic [ANGLE_W-1:0] out_z;
  logic               busy;

  modport slave (
    input  in_valid, in_mode, in_x, in_y, in_z, out_ready,
    output in_ready, out_valid, out_x, out_y, out_z, busy
  );

  modport master (
    output in_valid, in_mode, in_x, in_y, in_z, out_ready,
    input  in_ready, out_valid, out_x, out_y, out_z, busy
  );
endinterface

// File: rtl/cordic_iter.sv
// cordic_iter: iterative CORDIC engine, one micro-rotation per clock over a
// shared shift/add datapath, ITER cycles per operation.
//   clk, rst_n : clock, asynchronous active-low reset.
//   bus        : cordic_iter_if.slave (operand in, result out, busy).
//   in_mode    : 0 = rotation (z -> 0), 1 = vectoring (y -> 0).
//   out_x/y    : carry the CORDIC gain (~1.6468), not compensated.
// Optional macro CORDIC_QUAD_EXT_EN: +/-90 deg pre-rotation at accept for
// full-circle convergence, no added latency.
module cordic_iter #(
  parameter int DATA_W  = 17,
  parameter int ANGLE_W = 32,
  parameter int ITER    = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  cordic_iter_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

  localparam logic [4:0] I_LAST = 5'(ITER - 1);
  // +90 degrees in angle counts
  localparam logic signed [ANGLE_W-1:0] QTR = {2'b01, {(ANGLE_W-2){1'b0}}};

  state_t                    st, st_nxt;
  logic                      acc, last, dpos, mode_q;
  logic [4:0]                i_q;
  logic signed [DATA_W-1:0]  x_q, y_q, x_ld, y_ld, x_nx, y_nx, xs, ys;
  logic signed [ANGLE_W-1:0] z_q, z_ld, z_nx, atan_i;
  logic signed [DATA_W-1:0]  ox_q, oy_q;
  logic signed [ANGLE_W-1:0] oz_q;

  // round(atan(2^-i) * 2^32 / 2pi); 2^32 counts = full circle
  function automatic logic [31:0] atan32(input logic [4:0] i);
    case (i)
      5'd0:  atan32 = 32'h20000000;
      5'd1:  atan32 = 32'h12E4051E;
      5'd2:  atan32 = 32'h09FB385B;
      5'd3:  atan32 = 32'h051111D4;
      5'd4:  atan32 = 32'h028B0D43;
      5'd5:  atan32 = 32'h0145D7E1;
      5'd6:  atan32 = 32'h00A2F61E;
      5'd7:  atan32 = 32'h00517C55;
      5'd8:  atan32 = 32'h0028BE53;
      5'd9:  atan32 = 32'h00145F2F;
      5'd10: atan32 = 32'h000A2F98;
      5'd11: atan32 = 32'h000517CC;
      5'd12: atan32 = 32'h00028BE6;
      5'd13: atan32 = 32'h000145F3;
      5'd14: atan32 = 32'h0000A2FA;
      5'd15: atan32 = 32'h0000517D;
      5'd16: atan32 = 32'h000028BE;
      5'd17: atan32 = 32'h0000145F;
      5'd18: atan32 = 32'h00000A30;
      5'd19: atan32 = 32'h00000518;
      5'd20: atan32 = 32'h0000028C;
      5'd21: atan32 = 32'h00000146;
      5'd22: atan32 = 32'h000000A3;
      5'd23: atan32 = 32'h00000051;
      5'd24: atan32 = 32'h00000029;
      5'd25: atan32 = 32'h00000014;
      5'd26: atan32 = 32'h0000000A;
      5'd27: atan32 = 32'h00000005;
      5'd28: atan32 = 32'h00000003;
      5'd29: atan32 = 32'h00000001;
      5'd30: atan32 = 32'h00000001;
      default: atan32 = 32'h00000000;
    endcase
  endfunction

  // in_ready is gated by rst_n so nothing is offered while reset is held
  assign bus.in_ready  = rst_n & (st == IDLE);
  assign bus.out_valid = (st == DONE);
  assign bus.busy      = (st != IDLE);
  assign bus.out_x     = ox_q;
  assign bus.out_y     = oy_q;
  assign bus.out_z     = oz_q;

  assign acc  = bus.in_valid & bus.in_ready;
  assign last = (i_q == I_LAST);

  always_comb begin
    st_nxt = st;
    case (st)
      IDLE:    if (acc)           st_nxt = RUN;
      RUN:     if (last)          st_nxt = DONE;
      DONE:    if (bus.out_ready) st_nxt = IDLE;
      default:                    st_nxt = IDLE;
    endcase
  end

  // operand load path (optional quadrant pre-rotation)
  always_comb begin
    x_ld = bus.in_x;
    y_ld = bus.in_y;
    z_ld = bus.in_z;
`ifdef CORDIC_QUAD_EXT_EN
    if (!bus.in_mode) begin
      if ($signed(bus.in_z) >= QTR) begin
        x_ld = -$signed(bus.in_y);
        y_ld = bus.in_x;
        z_ld = $signed(bus.in_z) - QTR;
      end else if ($signed(bus.in_z) < -QTR) begin
        x_ld = bus.in_y;
        y_ld = -$signed(bus.in_x);
        z_ld = $signed(bus.in_z) + QTR;
      end
    end else if (bus.in_x[DATA_W-1]) begin
      if (!bus.in_y[DATA_W-1]) begin
        x_ld = bus.in_y;
        y_ld = -$signed(bus.in_x);
        z_ld = $signed(bus.in_z) + QTR;
      end else begin
        x_ld = -$signed(bus.in_y);
        y_ld = bus.in_x;
        z_ld = $signed(bus.in_z) - QTR;
      end
    end
`endif
  end

  // one micro-rotation; dpos selects d=+1
  assign dpos   = mode_q ? y_q[DATA_W-1] : ~z_q[ANGLE_W-1];
  assign xs     = x_q >>> i_q;
  assign ys     = y_q >>> i_q;
  assign atan_i = ANGLE_W'(atan32(i_q) >> (32 - ANGLE_W));
  assign x_nx   = dpos ? x_q - ys     : x_q + ys;
  assign y_nx   = dpos ? y_q + xs     : y_q - xs;
  assign z_nx   = dpos ? z_q - atan_i : z_q + atan_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) st <= IDLE;
    else        st <= st_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x_q    <= '0;
      y_q    <= '0;
      z_q    <= '0;
      i_q    <= '0;
      mode_q <= 1'b0;
      ox_q   <= '0;
      oy_q   <= '0;
      oz_q   <= '0;
    end else begin
      case (st)
        IDLE: if (acc) begin
          x_q    <= x_ld;
          y_q    <= y_ld;
          z_q    <= z_ld;
          mode_q <= bus.in_mode;
          i_q    <= '0;
        end
        RUN: begin
          x_q <= x_nx;
          y_q <= y_nx;
          z_q <= z_nx;
          i_q <= i_q + 5'd1;
          // result registers only move on the DONE entry edge
          if (last) begin
            ox_q <= x_nx;
            oy_q <= y_nx;
            oz_q <= z_nx;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter.sv
// tb_cordic_iter: randomized + directed bench for cordic_iter against a
// plain-arithmetic CORDIC reference (angle table built from $atan).
module tb_cordic_iter;
  localparam int DATA_W  = 17;
  localparam int ANGLE_W = 32;
  localparam int ITER    = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  cordic_iter_if #(.DATA_W(DATA_W), .ANGLE_W(ANGLE_W)) bus();
  cordic_iter #(.DATA_W(DATA_W), .ANGLE_W(ANGLE_W), .ITER(ITER)) dut (
    .clk(clk), .rst_n(rst_n), .bus(bus)
  );

  typedef struct { longint x; longint y; int z; } res_t;

  int     n_chk = 0, n_pass = 0;
  longint cyc = 0, last_acc = 0, last_hs = 0;
  bit     prev_ov = 1'b0;
  res_t   exp_q[$];

  task automatic chk(string tag, longint got, longint exp, longint tol = 0);
    n_chk++;
    if (got >= exp - tol && got <= exp + tol) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d (tol %0d)", tag, got, exp, tol);
  endtask

  function automatic longint wrapd(longint v);
    longint m = longint'(1) << DATA_W;
    longint r = v & (m - 1);
    if (r >= m / 2) r -= m;
    return r;
  endfunction

  function automatic int atan_cnt(int i);
    real pi = 3.14159265358979323846;
    real v  = $atan(2.0 ** (-i)) * (2.0 ** 32) / (2.0 * pi);
    return int'(longint'($rtoi(v + 0.5)) >> (32 - ANGLE_W));
  endfunction

  function automatic res_t cordic_ref(bit mode, longint xi, longint yi, int zi);
    res_t   r;
    longint x = xi, y = yi, t, xs, ys;
    int     z = zi;
    int     q = 1 << 30;
`ifdef CORDIC_QUAD_EXT_EN
    if (!mode) begin
      if (z >= q)       begin t = x; x = wrapd(-y); y = t; z = z - q; end
      else if (z < -q)  begin t = x; x = y; y = wrapd(-t); z = z + q; end
    end else if (x < 0) begin
      if (y >= 0) begin t = x; x = y; y = wrapd(-t); z = z + q; end
      else        begin t = x; x = wrapd(-y); y = t; z = z - q; end
    end
`else
    t = q;
`endif
    for (int i = 0; i < ITER; i++) begin
      xs = x >>> i;
      ys = y >>> i;
      if (mode ? (y < 0) : (z >= 0)) begin
        x = wrapd(x - ys); y = wrapd(y + xs); z = z - atan_cnt(i);
      end else begin
        x = wrapd(x + ys); y = wrapd(y - xs); z = z + atan_cnt(i);
      end
    end
    r.x = x; r.y = y; r.z = z;
    return r;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // handshake monitor: sampled mid-cycle, the next rising edge commits
  always @(negedge clk) begin
    res_t e;
    if (rst_n) begin
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(cordic_ref(bus.in_mode, $signed(bus.in_x),
                                   $signed(bus.in_y), $signed(bus.in_z)));
        last_acc = cyc + 1;
      end
      if (bus.out_valid && !prev_ov) chk("latency", cyc - last_acc, ITER);
      if (bus.out_valid && bus.out_ready) begin
        chk("result_pending", exp_q.size() > 0, 1);
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("res_x", $signed(bus.out_x), e.x);
          chk("res_y", $signed(bus.out_y), e.y);
          chk("res_z", $signed(bus.out_z), e.z);
        end
        last_hs = cyc + 1;
      end
    end
    prev_ov = bus.out_valid;
  end

  task automatic set_in(bit m, longint x, longint y, int z);
    bus.in_valid = 1'b1;
    bus.in_mode  = m;
    bus.in_x     = DATA_W'(x);
    bus.in_y     = DATA_W'(y);
    bus.in_z     = z;
  endtask

  task automatic set_rand();
    set_in(1'($urandom_range(0, 1)),
           longint'($urandom_range(0, 40000)) - 20000,
           longint'($urandom_range(0, 40000)) - 20000,
           int'($urandom));
  endtask

  task automatic wait_acc(bit keep);
    int k;
    for (k = 0; k < 200; k++) begin
      @(negedge clk);
      if (bus.in_ready) break;
    end
    chk("accept_timeout", k < 200, 1);
    @(posedge clk); #1;
    if (!keep) bus.in_valid = 1'b0;
  endtask

  task automatic wait_done();
    int k;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (bus.out_valid) break;
    end
    chk("done_timeout", k < 100, 1);
  endtask

  task automatic drive(bit m, longint x, longint y, int z);
    @(posedge clk); #1;
    set_in(m, x, y, z);
    wait_acc(1'b0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    longint sx, sy, sz, prev;
    bit     seen;
    bus.in_valid = 1'b0; bus.in_mode = 1'b0;
    bus.in_x = '0; bus.in_y = '0; bus.in_z = '0;
    bus.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    chk("rst_in_ready",  bus.in_ready,  0);
    chk("rst_out_valid", bus.out_valid, 0);
    chk("rst_busy",      bus.busy,      0);
    chk("rst_out_x",     bus.out_x,     0);
    chk("rst_out_y",     bus.out_y,     0);
    chk("rst_out_z",     bus.out_z,     0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    chk("rel_in_ready", bus.in_ready, 1);
    chk("rel_busy",     bus.busy,     0);

    // rotation by 45 degrees
    bus.out_ready = 1'b1;
    drive(1'b0, 19898, 0, 32'h20000000);
    wait_done();
    chk("rot_x", $signed(bus.out_x), 23170, 4);
    chk("rot_y", $signed(bus.out_y), 23170, 4);
    chk("rot_z", $signed(bus.out_z), 0, 1 << 18);

    // vectoring
    drive(1'b1, 10000, 10000, 0);
    wait_done();
    chk("vec_x", $signed(bus.out_x), 23289, 4);
    chk("vec_y", $signed(bus.out_y), 0, 4);
    chk("vec_z", $signed(bus.out_z), 32'h20000000, 1 << 18);

    // backpressure
    @(posedge clk); #1 bus.out_ready = 1'b0;
    @(posedge clk); #1 set_rand();
    wait_acc(1'b0);
    wait_done();
    sx = bus.out_x; sy = bus.out_y; sz = bus.out_z;
    @(posedge clk); #1 set_rand();
    repeat (5) begin
      @(negedge clk);
      chk("bp_valid",    bus.out_valid, 1);
      chk("bp_in_ready", bus.in_ready,  0);
      chk("bp_busy",     bus.busy,      1);
      chk("bp_x", bus.out_x, sx);
      chk("bp_y", bus.out_y, sy);
      chk("bp_z", bus.out_z, sz);
    end
    @(posedge clk); #1 bus.out_ready = 1'b1;
    wait_acc(1'b0);
    chk("bp_next_accept", last_acc - last_hs, 1);
    wait_done();

    // reset in the middle of RUN at i=7
    @(posedge clk); #1 set_rand();
    wait_acc(1'b0);
    repeat (7) @(posedge clk);
    #1 rst_n = 1'b0;
    @(negedge clk);
    exp_q.delete();
    chk("mid_rst_valid",    bus.out_valid, 0);
    chk("mid_rst_busy",     bus.busy,      0);
    chk("mid_rst_in_ready", bus.in_ready,  0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_in_ready", bus.in_ready, 1);
    chk("post_rst_busy",     bus.busy,     0);
    seen = 1'b0;
    repeat (ITER + 4) begin
      @(negedge clk);
      seen |= bus.out_valid;
    end
    chk("post_rst_no_pulse", seen, 0);
    @(posedge clk); #1 set_rand();
    wait_acc(1'b0);
    wait_done();

    // back-to-back with in_valid and out_ready held high
    @(posedge clk); #1 set_rand();
    prev = 0;
    for (int n = 0; n < 12; n++) begin
      wait_acc(1'b1);
      if (n > 0) chk("b2b_gap", last_acc - prev, ITER + 2);
      prev = last_acc;
      if (n < 11) set_rand();
      else        bus.in_valid = 1'b0;
    end

`ifdef CORDIC_QUAD_EXT_EN
    wait_done();
    drive(1'b0, 19898, 0, 32'h60000000);
    wait_done();
    chk("quad_rot_x", $signed(bus.out_x), -23170, 4);
    chk("quad_rot_y", $signed(bus.out_y), 23170, 4);
`endif

    repeat (ITER + 4) @(negedge clk);
    chk("queue_drained", exp_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule

// File: doc/cordic_iter.md
# cordic_iter

Iterative, parametrised CORDIC engine. It replaces the fixed-width, purely combinational single micro-rotation stage with a sequential core that reuses one shift/add datapath for ITER cycles. It supports rotation and vectoring modes and has valid/ready handshakes on input and output. It sits between the sample front-end and the magnitude/phase consumers of the processor.

## Interface
Parameters:
- DATA_W, 17: width of x/y, two's complement.
- ANGLE_W, 32: width of z, two's complement; 2^ANGLE_W counts = 360°; legal range 8..32.
- ITER, 16: micro-rotations per operation; legal range 1..min(DATA_W-1, 31).

Ports:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  input operand valid.
- in_ready  out  1  core can accept an operand.
- in_mode  in  1  0 = rotation (drive z→0), 1 = vectoring (drive y→0).
- in_x, in_y  in  DATA_W  input vector.
- in_z  in  ANGLE_W  input angle.
- out_valid  out  1  result valid.
- out_ready  in  1  consumer accepts result.
- out_x, out_y  out  DATA_W  result vector (gain K≈1.6468 not removed).
- out_z  out  ANGLE_W  residual/accumulated angle.
- busy  out  1  high in RUN or DONE.

## Operation
- The FSM has three states: IDLE, RUN and DONE. Reset forces IDLE.
- **IDLE:** in_ready=1.
  - An in_valid&in_ready edge latches x, y, z and mode, applying the pre-rotation under CORDIC_QUAD_EXT_EN.
  - The same edge clears iteration counter i to 0 and moves to RUN.
- **RUN:** one micro-rotation per cycle at index i.
  - d=+1 if (mode=0 and z≥0) or (mode=1 and y<0); otherwise d=−1.
  - x ← x − d·(y>>>i)
  - y ← y + d·(x>>>i)
  - z ← z − d·atan(i)
  - All right-hand sides use the register values from the start of the cycle.
  - Shifts are arithmetic (floor).
  - atan(i) is an internal constant table of round(atan(2^−i)·2^32/2π) in 32 bits, right-shifted by 32−ANGLE_W.
  - Add/subtract wraps modulo 2^width. There is no saturation; keeping |input|·1.65 < 2^(DATA_W−1) is the caller's responsibility.
  - After the micro-rotation with i=ITER−1, go to DONE.
- **DONE:** out_valid=1 and outputs are held stable.
  - An out_valid&out_ready edge moves to IDLE.
  - in_ready stays 0 in RUN and DONE; no operand is accepted until IDLE.
- **Mode:** in_mode is sampled only at the accept edge. Changing it later has no effect.
- **Reset mid-operation:** asserting rst_n low in any state aborts the operation. The result is discarded and no out_valid pulse is emitted.

## Timing
- Reset values: in_ready=0 while rst_n=0 and 1 from the first cycle after release. out_valid=0, busy=0, out_x=out_y=0, out_z=0.
- Latency: accept at edge A. out_valid rises after edge A+ITER.
- Minimum period: the earliest next accept is edge A+ITER+2 when out_ready is held 1. Throughput is 1 per ITER+2 cycles.
- out_x/out_y/out_z are registered and change only at the cycle that enters DONE.
- out_valid may be waited on indefinitely; it does not drop without a handshake.
- out_ready while out_valid=0 is ignored.

## Configuration
The macro is CORDIC_QUAD_EXT_EN. It adds full-circle range at the accept edge with no extra latency.
- **Defined, rotation mode:**
  - If z ≥ +90°, load x=−y, y=x, z=z−90°.
  - If z < −90°, load x=y, y=−x, z=z+90°.
- **Defined, vectoring mode:**
  - If x<0 and y≥0, load x=y, y=−x, z=z+90°.
  - If x<0 and y<0, load x=−y, y=x, z=z−90°.
- **Undefined:** operands are loaded unchanged. Convergence is guaranteed only for |z|<≈99.7° in rotation mode and x≥0 in vectoring mode.

## Test plan
All scenarios use the default parameters. Tolerance is ±4 LSB on x/y and ±2^18 on z.
- Rotation: x=19898, y=0, z=0x20000000 (45°) → out_x≈23170, out_y≈23170, out_z≈0. out_valid rises 16 edges after the accept edge.
- Vectoring: x=10000, y=10000, z=0 → out_x≈23289, out_y≈0, out_z≈0x20000000.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid. Outputs stay stable, in_ready stays 0 and the second operand waits. Then raise out_ready; the next accept follows within 1 cycle.
- Reset mid-RUN: pull rst_n low at i=7. out_valid stays 0, busy=0 and in_ready=1 after release. A fresh operand then yields a correct result.
- Back-to-back: with in_valid and out_ready tied 1, accepts are exactly 18 cycles apart.
- Macro defined, rotation: x=19898, y=0, z=0x60000000 (135°) → out_x≈−23170, out_y≈23170. Without the macro this case is not checked.
